// File: rtl/table_sched.sv
`default_nettype none
// ============================================================================
// Module      : table_sched
// Description : Round-robin scheduler that shares one multiplication-table
//               engine among NREQ requesters. A granted requester's table
//               a*1 .. a*n is streamed on a valid/ready port. Each row carries
//               the requester id and the row index. Products are built by
//               repeated addition.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               req_valid/a/n        - per-requester request, operand, length
//               req_ack, done        - one-hot pulses: captured / finished
//               busy                 - engine is streaming a table
//               out_valid/ready      - row handshake
//               out_data/idx/id/last - product, multiplier, owner, final row
// Revision    : 1.0 - initial release
// ============================================================================
module table_sched #(
    parameter int NREQ = 4,
    parameter int W    = 10,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*4-1:0] req_n,
    output logic [NREQ-1:0]   req_ack,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W+3:0]      out_data,
    output logic [3:0]        out_idx,
    output logic [IW-1:0]     out_id,
    output logic              out_last
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [W-1:0]    a_q;
    logic [3:0]      n_q;
    logic [NREQ-1:0] req_ack_q;
    logic [NREQ-1:0] done_q;
    logic            busy_q;
    logic            out_valid_q;
    logic [W+3:0]    out_data_q;
    logic [3:0]      out_idx_q;
    logic [IW-1:0]   out_id_q;
    logic            out_last_q;

    logic            w_found;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_cand;
    logic [W-1:0]    w_win_a;
    logic [3:0]      w_win_n;

    // Rotating priority search starting at ptr. NREQ is a power of two,
    // so the IW-bit addition wraps exactly modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = ptr_q;
        w_cand  = ptr_q;
        w_win_a = '0;
        w_win_n = '0;
        for (int j = 0; j < NREQ; j++) begin
            w_cand = ptr_q + IW'(j);
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            if (w_win == IW'(k)) begin
                w_win_a = req_a[k*W +: W];
                w_win_n = req_n[k*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            n_q         <= '0;
            req_ack_q   <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            // ack and done are single-cycle pulses
            req_ack_q <= '0;
            done_q    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (w_found) begin
                        req_ack_q[w_win] <= 1'b1;
                        ptr_q            <= w_win + IW'(1);
                        a_q              <= w_win_a;
                        n_q              <= w_win_n;
                        if (w_win_n != 4'd0) begin
                            // First row is a*1, presented together with the ack
                            state_q     <= S_RUN;
                            busy_q      <= 1'b1;
                            out_valid_q <= 1'b1;
                            out_data_q  <= {4'b0000, w_win_a};
                            out_idx_q   <= 4'd1;
                            out_id_q    <= w_win;
                            out_last_q  <= (w_win_n == 4'd1);
                        end else begin
                            // Empty table: finish in the same cycle as the ack
                            done_q[w_win] <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (out_valid_q && out_ready) begin
                        if (out_idx_q < n_q) begin
                            out_data_q <= out_data_q + {4'b0000, a_q};
                            out_idx_q  <= out_idx_q + 4'd1;
                            out_last_q <= ((out_idx_q + 4'd1) == n_q);
                        end else begin
                            state_q          <= S_IDLE;
                            busy_q           <= 1'b0;
                            out_valid_q      <= 1'b0;
                            out_last_q       <= 1'b0;
                            done_q[out_id_q] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack   = req_ack_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_table_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_table_sched
// Description : Self-checking bench for table_sched. A reference model
//               derives the grant order from the round-robin rule. It
//               derives each row as a*i and the ack/done timing from the
//               cycle-level protocol rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_table_sched;

    localparam int NREQ = 4;
    localparam int W    = 10;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*W-1:0] req_a = '0;
    logic [NREQ*4-1:0] req_n = '0;
    logic [NREQ-1:0]   req_ack;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W+3:0]      out_data;
    logic [3:0]        out_idx;
    logic [IW-1:0]     out_id;
    logic              out_last;

    table_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_n     (req_n),
        .req_ack   (req_ack),
        .done      (done),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int a;
        int n;
        int exp_rows;
        int exp_last;
    } vec_t;

    vec_t vecs[6];
    int   checks = 0;
    int   errors = 0;
    int   a_arr[NREQ];
    int   n_arr[NREQ];
    int   m_ptr = 0;
    int   grant_log[$];
    int   acc_log[$];
    int   rdy_pat[$];
    int   busy_cnt;
    int   first_ack_cycle;
    int   last_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive_data();
        for (int k = 0; k < NREQ; k++) begin
            req_a[k*W +: W] = W'(a_arr[k]);
            req_n[k*4 +: 4] = 4'(n_arr[k]);
        end
    endtask

    // Presents the requests in mask, then follows the whole exchange cycle by
    // cycle until every granted table has finished.
    // mode 0: out_ready always 1; 1: random ready and re-randomized operands
    // after capture; 2: ready taken from rdy_pat.
    task automatic serve(input logic [NREQ-1:0] mask, input int mode);
        int              order[$];
        int              p;
        logic [NREQ-1:0] pend;
        int              cycle;
        int              next_ack;
        bit              act;
        int              cid, ca, cn, ci, g;
        logic [NREQ-1:0] done_due, exp_ack, exp_done;
        bit              r;

        // Expected grant order: first pending id at or after the pointer
        pend = mask;
        p    = m_ptr;
        while (pend != '0) begin
            for (int j = 0; j < NREQ; j++) begin
                int k;
                k = (p + j) % NREQ;
                if (pend[k]) begin
                    order.push_back(k);
                    pend[k] = 1'b0;
                    p = (k + 1) % NREQ;
                    break;
                end
            end
        end
        m_ptr = p;

        grant_log = {};
        acc_log   = {};
        busy_cnt  = 0;
        first_ack_cycle = -1;
        last_data = -1;
        drive_data();
        req_valid = mask;
        cycle = 0; next_ack = 1; act = 0; done_due = '0;
        cid = 0; ca = 0; cn = 0; ci = 0; g = 0;

        while (1) begin
            @(negedge clk);
            cycle++;
            exp_ack  = '0;
            exp_done = done_due;
            done_due = '0;
            if (order.size() > 0 && cycle == next_ack) begin
                g = order.pop_front();
                grant_log.push_back(g);
                if (first_ack_cycle < 0) first_ack_cycle = cycle;
                exp_ack[g] = 1'b1;
                if (n_arr[g] == 0) begin
                    exp_done[g] = 1'b1;
                    next_ack = cycle + 1;
                end else begin
                    act = 1; cid = g; ca = a_arr[g]; cn = n_arr[g]; ci = 1;
                end
            end
            chk("req_ack", req_ack, exp_ack);
            chk("done", done, exp_done);
            chk("busy", busy, act);
            chk("out_valid", out_valid, act);
            if (act) begin
                chk("out_data", out_data, ca * ci);
                chk("out_idx", out_idx, ci);
                chk("out_id", out_id, cid);
                chk("out_last", out_last, (ci == cn));
            end
            if (busy) busy_cnt++;
            if (exp_ack != '0) begin
                req_valid[g] = 1'b0;
                if (mode == 1) begin
                    a_arr[g] = $urandom_range(0, 1023);
                    n_arr[g] = $urandom_range(0, 15);
                    drive_data();
                end
            end
            if (act) begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ($urandom_range(0, 3) != 0);
                    default: r = (rdy_pat.size() > 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
                endcase
                out_ready = r;
                if (r) begin
                    acc_log.push_back(ca * ci);
                    last_data = ca * ci;
                    if (ci == cn) begin
                        act = 0;
                        done_due[cid] = 1'b1;
                        next_ack = cycle + 2;   // done cycle, then capture
                    end else begin
                        ci++;
                    end
                end
            end else begin
                out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (order.size() == 0 && !act && done_due == '0) break;
            if (cycle > 2000) begin
                checks++;
                errors++;
                $display("FAIL serve_timeout actual=%0d required=<2000 cycles", cycle);
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, req_ack, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_id"}, out_id, 0);
        chk({tag, "_last"}, out_last, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_wait;
        for (int k = 0; k < NREQ; k++) begin a_arr[k] = 0; n_arr[k] = 0; end
        vecs[0] = '{id: 0, a: 2,    n: 10, exp_rows: 10, exp_last: 20};
        vecs[1] = '{id: 2, a: 5,    n: 0,  exp_rows: 0,  exp_last: -1};
        vecs[2] = '{id: 1, a: 7,    n: 3,  exp_rows: 3,  exp_last: 21};
        vecs[3] = '{id: 3, a: 1023, n: 15, exp_rows: 15, exp_last: 15345};
        vecs[4] = '{id: 0, a: 1023, n: 1,  exp_rows: 1,  exp_last: 1023};
        vecs[5] = '{id: 2, a: 1,    n: 1,  exp_rows: 1,  exp_last: 1};

        // Reset state
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        m_ptr = 0;

        // Single-requester tables from the vector table
        for (int v = 0; v < 6; v++) begin
            a_arr[vecs[v].id] = vecs[v].a;
            n_arr[vecs[v].id] = vecs[v].n;
            serve(NREQ'(1) << vecs[v].id, 0);
            chk("vec_ack_latency", first_ack_cycle, 1);
            chk("vec_rows", acc_log.size(), vecs[v].exp_rows);
            chk("vec_last_data", last_data, vecs[v].exp_last);
            chk("vec_busy_cycles", busy_cnt, vecs[v].exp_rows);
        end

        // Zero length on requester 2 moves the pointer to 3
        a_arr[2] = 9; n_arr[2] = 0;
        serve(4'b0100, 0);
        chk("zero_no_rows", acc_log.size(), 0);
        a_arr[0] = 1; n_arr[0] = 1;
        a_arr[3] = 2; n_arr[3] = 1;
        serve(4'b1001, 0);
        chk("ptr_after_zero", grant_log[0], 3);

        // Round-robin from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        for (int k = 0; k < NREQ; k++) begin a_arr[k] = k + 1; n_arr[k] = 2; end
        serve(4'b1111, 0);
        for (int k = 0; k < NREQ; k++) chk("rr_order", grant_log[k], k);
        serve(4'b1001, 0);
        chk("rr_resume_first", grant_log[0], 0);
        chk("rr_resume_second", grant_log[1], 3);

        // Backpressure: ready 1,0,0,1,1 on a=7, n=3
        a_arr[1] = 7; n_arr[1] = 3;
        rdy_pat = '{1, 0, 0, 1, 1};
        serve(4'b0010, 2);
        chk("bp_count", acc_log.size(), 3);
        chk("bp_row1", acc_log[0], 7);
        chk("bp_row2", acc_log[1], 14);
        chk("bp_row3", acc_log[2], 21);

        // Randomized rounds with random ready and random operands
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < NREQ; k++) begin
                a_arr[k] = $urandom_range(0, 1023);
                n_arr[k] = $urandom_range(0, 15);
            end
            serve(4'($urandom_range(1, 15)), 1);
        end

        // Reset during row 4 of an n=10 table
        a_arr[1] = 3; n_arr[1] = 10;
        drive_data();
        out_ready = 1'b1;
        req_valid = 4'b0010;
        n_wait = 0;
        while (n_wait < 30) begin
            @(negedge clk);
            n_wait++;
            if (req_ack != '0) req_valid = '0;
            if (out_valid && out_idx == 4'd4) break;
        end
        req_valid = '0;
        chk("mid_reach_row4", out_idx, 4);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            chk("mid_no_done", done, 0);
            chk("mid_no_valid", out_valid, 0);
        end
        rst_n = 1'b1;
        m_ptr = 0;
        a_arr[1] = 4; n_arr[1] = 3;
        a_arr[3] = 6; n_arr[3] = 2;
        serve(4'b1010, 0);
        chk("post_reset_first_grant", grant_log[0], 1);
        chk("post_reset_first_row", acc_log[0], 4);
        chk("post_reset_rows", acc_log.size(), 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/table_sched.md
# table_sched

Round-robin scheduler that shares one multiplication-table engine among `NREQ` requesters. Each requester submits a base operand `a` and a table length `n`. The engine streams rows `a*1 … a*n` on a valid/ready output, tagged with requester id and row index. Products come from repeated addition, with no multiplier, and the block is the front end for every table-generation client in the design.

## Interface
- `NREQ`, 4: number of requesters; must be a power of two, 2..16.
- `W`, 10: operand width.
- `IW`, log2(NREQ): id width; derived, do not override.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: bit k high means requester k has a pending request.
- `req_a` in NREQ*W: requester k operand at bits [k*W +: W].
- `req_n` in NREQ*4: requester k table length (0..15) at bits [k*4 +: 4].
- `req_ack` out NREQ: one-hot, one-cycle pulse; the request was captured.
- `done` out NREQ: one-hot, one-cycle pulse; the table for that requester is finished.
- `busy` out 1: high while in RUN.
- `out_valid` out 1: a row is presented.
- `out_ready` in 1: the sink accepts the row.
- `out_data` out W+4: product a*i, full width, never truncated.
- `out_idx` out 4: multiplier i (1..n).
- `out_id` out IW: id of the owning requester.
- `out_last` out 1: high when out_idx == n.

## Operation
- States: IDLE and RUN. Round-robin pointer `ptr` (IW bits).
- Reset, asynchronous on `rst_n` low, clears everything to zero:
  - state = IDLE, `ptr` = 0.
  - `req_ack`, `done`, `busy`, `out_valid`, `out_data`, `out_idx`, `out_id`, `out_last` all 0.
- IDLE, with any `req_valid` bit high:
  - Winner = first set bit searching `ptr`, `ptr`+1, … modulo NREQ.
  - Capture `a`, `n` and `id` of the winner.
  - `req_ack[id]` pulses for the next cycle.
  - `ptr` ← id+1 mod NREQ.
- IDLE, winner with n ≥ 1:
  - Next state RUN.
  - Next-cycle outputs: `out_data` = a, `out_idx` = 1, `out_valid` = 1, `out_last` = (n == 1).
- IDLE, winner with n == 0:
  - State stays IDLE and no row is emitted.
  - `done[id]` pulses in the same cycle as `req_ack[id]`.
- RUN, on `out_valid && out_ready`:
  - If `out_idx` < n: `out_data` += a, `out_idx` += 1, `out_last` = (out_idx+1 == n).
  - If `out_idx` == n: `out_valid` ← 0, state ← IDLE, `done[id]` pulses next cycle.
- RUN, on `out_valid && !out_ready`: all `out_*` signals hold stable.
- Requests are not arbitrated in RUN. Pending `req_valid` bits wait until IDLE.
- Requester contract: drop `req_valid` in the cycle `req_ack` is seen. A requester still asserting `req_valid` in IDLE is treated as a new request.
- `req_a` and `req_n` are sampled only at the capture edge. Later changes do not affect the running table.
- Width: accumulator is W+4 bits; max 15*(2^W−1) fits, so no overflow is possible.

## Timing
- Capture edge E0, in IDLE with `req_valid` high:
  - `req_ack` and the first row are both visible in the cycle after E0.
  - `busy` = 1 from that cycle.
- With `out_ready` held high: one row per cycle, n consecutive `out_valid` cycles.
- `done` pulses in the cycle after the handshake of the last row. `busy` = 0 in that same cycle.
- The `done` cycle is IDLE, so a new capture can occur at the end of that cycle.
- Back-to-back tables: gap of exactly one cycle with `out_valid` low between the last row of one table and the first row of the next.
- Reset asserted mid-table: the table is aborted immediately with no `done` pulse. After release, a requester must re-request.
- Simultaneous requests: exactly one ack per capture edge, with order set by `ptr`.

## Test plan
- **Single table:** reset, then req_valid[0] with a=2, n=10, out_ready=1.
  - req_ack[0] appears one cycle after sampling.
  - Rows 2,4,…,20 arrive with idx 1..10; out_last only on 20.
  - done[0] pulses one cycle after the last row; busy is high for exactly 10 cycles.
- **Round-robin:** all 4 requesters assert at once with a=k+1, n=2.
  - Grant order is 0,1,2,3.
  - Re-assert requesters 0 and 3: order is 0 then 3 (ptr resumed at 0 after granting 3).
- **Backpressure:** a=7, n=3, out_ready toggling 1,0,0,1,1.
  - out_data/out_idx hold at 14/2 through the stall cycles.
  - Sequence is exactly 7,14,21 with no duplicates or drops.
- **Zero length:** req_n[2]=0.
  - req_ack[2] and done[2] pulse in the same cycle; out_valid stays 0; ptr advances to 3.
- **Full width:** a=1023, n=15 → last out_data = 15345, with no truncation.
- **Reset mid-run:** drop rst_n during row 4 of an n=10 table.
  - All outputs read 0 immediately and no done pulse occurs.
  - After release, a new request restarts from idx 1.
